// File: rtl/irq_controller.sv
// Edge-triggered 8-line interrupt controller with a fixed-priority selector
// and a four-state handshake FSM towards the context-save sequencer.
module irq_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_system,
  input  logic [7:0]  irq_in,
  input  logic        do_syscall_it,
  input  logic        do_interrupt,
  input  logic        do_it_return,
  input  logic        do_it_state,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [7:0]  cfg_wdata,
  output logic [7:0]  cfg_rdata,
  output logic        do_hw_it,
  output logic [31:0] irq_pc,
  output logic [2:0]  irq_id,
  output logic        irq_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [7:0]  irq_prev_r;
  logic [7:0]  pending_r, pending_next_s;
  logic [7:0]  mask_r;
  logic [7:0]  inservice_r, inservice_next_s;
  logic        do_hw_it_r, do_hw_it_next_s;
  logic        irq_active_r, irq_active_next_s;
  logic [2:0]  irq_id_r, irq_id_next_s;
  logic [31:0] irq_pc_r, irq_pc_next_s;
  logic [7:0]  edge_s;
  logic [7:0]  w1c_s;
  logic [7:0]  grant_clr_s;
  logic [7:0]  eligible_s;
  logic        cand_valid_s;
  logic [2:0]  cand_id_s;
  logic        grant_s;

  assign edge_s     = irq_in & ~irq_prev_r;
  assign eligible_s = pending_r & mask_r;

  // Lowest eligible index wins; scan from the top so index 0 overrides.
  always_comb begin
    cand_valid_s = 1'b0;
    cand_id_s    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible_s[i]) begin
        cand_valid_s = 1'b1;
        cand_id_s    = 3'(i);
      end else begin
        cand_valid_s = cand_valid_s;
      end
    end
  end

  // Pending update: W1C and grant clear, with a fresh edge always winning.
  always_comb begin
    w1c_s          = (cfg_we && (cfg_addr == 2'd1)) ? cfg_wdata : 8'h00;
    grant_clr_s    = grant_s ? (8'd1 << cand_id_s) : 8'h00;
    pending_next_s = (pending_r & ~w1c_s & ~grant_clr_s) | edge_s;
  end

  // Edge history, pending capture and mask writes run regardless of enable_system.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_prev_r <= 8'h00;
      pending_r  <= 8'h00;
      mask_r     <= 8'h00;
    end else begin
      irq_prev_r <= irq_in;
      pending_r  <= pending_next_s;
      if (cfg_we && (cfg_addr == 2'd0)) begin
        mask_r <= cfg_wdata;
      end
    end
  end

  // FSM next-state and next-output logic; everything holds when disabled.
  always_comb begin
    state_next_s      = state_r;
    grant_s           = 1'b0;
    do_hw_it_next_s   = do_hw_it_r;
    irq_active_next_s = irq_active_r;
    inservice_next_s  = inservice_r;
    irq_id_next_s     = irq_id_r;
    irq_pc_next_s     = irq_pc_r;
    if (enable_system) begin
      case (state_r)
        IDLE: begin
          if (cand_valid_s && !do_syscall_it && !do_it_state) begin
            state_next_s    = REQ;
            grant_s         = 1'b1;
            do_hw_it_next_s = 1'b1;
            irq_id_next_s   = cand_id_s;
            irq_pc_next_s   = 32'h0000_0008 + {27'd0, cand_id_s, 2'b00};
          end else begin
            do_hw_it_next_s = 1'b0;
          end
        end
        REQ: begin
          if (do_interrupt) begin
            state_next_s      = SERVICE;
            do_hw_it_next_s   = 1'b0;
            inservice_next_s  = 8'd1 << irq_id_r;
            irq_active_next_s = 1'b1;
          end else begin
            do_hw_it_next_s = 1'b1;
          end
        end
        SERVICE: begin
          if (do_it_return) begin
            state_next_s      = DRAIN;
            inservice_next_s  = 8'h00;
            irq_active_next_s = 1'b0;
          end else begin
            state_next_s = SERVICE;
          end
        end
        DRAIN: begin
          // Residency of at least one cycle is implicit: the test only
          // happens once the state register already reads DRAIN.
          if (!do_it_state) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = DRAIN;
          end
        end
        default: begin
          state_next_s      = IDLE;
          do_hw_it_next_s   = 1'b0;
          irq_active_next_s = 1'b0;
          inservice_next_s  = 8'h00;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      do_hw_it_r   <= 1'b0;
      irq_active_r <= 1'b0;
      inservice_r  <= 8'h00;
      irq_id_r     <= 3'd0;
      irq_pc_r     <= 32'h0000_0000;
    end else begin
      state_r      <= state_next_s;
      do_hw_it_r   <= do_hw_it_next_s;
      irq_active_r <= irq_active_next_s;
      inservice_r  <= inservice_next_s;
      irq_id_r     <= irq_id_next_s;
      irq_pc_r     <= irq_pc_next_s;
    end
  end

  // Register read mux.
  always_comb begin
    case (cfg_addr)
      2'd0:    cfg_rdata = mask_r;
      2'd1:    cfg_rdata = pending_r;
      2'd2:    cfg_rdata = inservice_r;
      2'd3:    cfg_rdata = {5'b00000, irq_active_r, state_r};
      default: cfg_rdata = 8'h00;
    endcase
  end

  assign do_hw_it   = do_hw_it_r;
  assign irq_pc     = irq_pc_r;
  assign irq_id     = irq_id_r;
  assign irq_active = irq_active_r;

endmodule
